// File: rtl/gpio_param_writer_if.sv
// Host-side GPIO word pair plus the parameter bank and commit strobe of one set.
// master = host/testbench side, slave = gpio_param_writer side.
`timescale 1ns/1ps
interface gpio_param_writer_if #(
   parameter int GPIO_WIDTH  = 32,
   parameter int PARAM_COUNT = 16
);
   logic [GPIO_WIDTH-1:0]             GP_IN;
   logic [3:0]                        SET;
   logic [GPIO_WIDTH-1:0]             GP_OUT;
   logic [PARAM_COUNT*GPIO_WIDTH-1:0] PARAMS_DATA;
   logic                              UPDATE;
   logic [3:0]                        UPDATE_IDX;

   modport master (
      output GP_IN, SET,
      input  GP_OUT, PARAMS_DATA, UPDATE, UPDATE_IDX
   );

   modport slave (
      input  GP_IN, SET,
      output GP_OUT, PARAMS_DATA, UPDATE, UPDATE_IDX
   );
endinterface

// File: rtl/gpio_param_writer.sv
// Toggle-handshake write path: host issues CMD / DATA_LO / DATA_HI / ABORT words on GP_IN,
// each word is processed two edges after its TGL flip is sampled and commits into the bank.
`timescale 1ns/1ps
module gpio_param_writer #(
   parameter int GPIO_WIDTH  = 32,
   parameter int PARAM_COUNT = 16
) (
   input  logic                CLK,
   input  logic                RST,
   gpio_param_writer_if.slave  bus
);
   localparam int W = GPIO_WIDTH;
   localparam int H = GPIO_WIDTH / 2;
   localparam logic [4:0] PCNT = 5'(PARAM_COUNT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_LO = 2'd1,
      S_WAIT_HI = 2'd2
   } state_t;

   localparam logic [1:0] K_CMD   = 2'b00;
   localparam logic [1:0] K_LO    = 2'b01;
   localparam logic [1:0] K_HI    = 2'b10;
   localparam logic [1:0] K_ABORT = 2'b11;

   logic [W-1:0]             sync1_q, sync2_q;
   logic                     tgl_prev_q;
   state_t                   state_q, state_d;
   logic                     err_q, err_d;
   logic                     ign_q, ign_d;
   logic                     ack_q, ack_d;
   logic [3:0]               idx_q, idx_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [H-1:0]             lo_q, lo_d;
   logic [PARAM_COUNT*W-1:0] bank_q, bank_d;
   logic                     upd_q, upd_d;
   logic [3:0]               upd_idx_q, upd_idx_d;

   logic                     word_vld;
   logic [1:0]               w_kind;
   logic [3:0]               w_set;
   logic [3:0]               w_idx;
   logic [H-1:0]             w_pay;
   logic                     idx_ok;
   logic                     unused_bits;

   // Decode from the second stage; the previous-TGL flop marks a new word.
   assign word_vld    = sync2_q[W-1] != tgl_prev_q;
   assign w_kind      = sync2_q[W-2:W-3];
   assign w_set       = sync2_q[W-5:W-8];
   assign w_idx       = sync2_q[3:0];
   assign w_pay       = sync2_q[H-1:0];
   assign idx_ok      = {1'b0, w_idx} < PCNT;
   assign unused_bits = ^sync2_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         tgl_prev_q <= 1'b0;
         state_q    <= S_IDLE;
         err_q      <= 1'b0;
         ign_q      <= 1'b0;
         ack_q      <= 1'b0;
         idx_q      <= '0;
         cnt_q      <= '0;
         lo_q       <= '0;
         bank_q     <= '0;
         upd_q      <= 1'b0;
         upd_idx_q  <= '0;
      end else begin
         sync1_q    <= bus.GP_IN;
         sync2_q    <= sync1_q;
         tgl_prev_q <= sync2_q[W-1];
         state_q    <= state_d;
         err_q      <= err_d;
         ign_q      <= ign_d;
         ack_q      <= ack_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         lo_q       <= lo_d;
         bank_q     <= bank_d;
         upd_q      <= upd_d;
         upd_idx_q  <= upd_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      ign_d     = ign_q;
      ack_d     = ack_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      lo_d      = lo_q;
      bank_d    = bank_q;
      upd_d     = 1'b0;
      upd_idx_d = upd_idx_q;
      if (word_vld) begin
         ack_d = sync2_q[W-1];
         unique case (w_kind)
            K_CMD: begin
               if (w_set == bus.SET) begin
                  if (idx_ok) begin
                     idx_d   = w_idx;
                     err_d   = 1'b0;
                     ign_d   = 1'b0;
                     state_d = S_WAIT_LO;
                  end else begin
                     err_d   = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  ign_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
            K_LO: begin
               if (state_q == S_WAIT_LO) begin
                  lo_d    = w_pay;
                  state_d = S_WAIT_HI;
               end else if (!(state_q == S_IDLE && ign_q)) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
            K_HI: begin
               if (state_q == S_WAIT_HI) begin
                  for (int i = 0; i < PARAM_COUNT; i++) begin
                     if (idx_q == 4'(i)) bank_d[i*W +: W] = {w_pay, lo_q};
                  end
                  upd_d     = 1'b1;
                  upd_idx_d = idx_q;
                  cnt_d     = cnt_q + 4'd1;
                  state_d   = S_IDLE;
               end else if (!(state_q == S_IDLE && ign_q)) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
            K_ABORT: begin
               err_d   = 1'b0;
               ign_d   = 1'b0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.GP_OUT          = '0;
      bus.GP_OUT[W-1]     = ack_q;
      bus.GP_OUT[W-2]     = err_q;
      bus.GP_OUT[W-3:W-4] = state_q;
      bus.GP_OUT[7:4]     = cnt_q;
      bus.GP_OUT[3:0]     = idx_q;
   end

   assign bus.PARAMS_DATA = bank_q;
   assign bus.UPDATE      = upd_q;
   assign bus.UPDATE_IDX  = upd_idx_q;
endmodule

// File: doc/gpio_param_writer.md
# gpio_param_writer

- Write path of the GPIO parameter interface: the host pushes parameter words into a per-set register bank through a single GPIO word, using a toggle handshake.
- Bank output `PARAMS_DATA` has the same packed layout the GPIO parameter read-back block consumes: slot i at `[i*GPIO_WIDTH +: GPIO_WIDTH]`. Host writes and reads back through the same GPIO pair.
- One instance per parameter set; instances share `GP_IN` and are distinguished by `SET`.

## Interface
- `GPIO_WIDTH`, 32, GPIO word width. Must be even and ≥16.
- `PARAM_COUNT`, 16, number of parameter slots, 1..16.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  reset, asynchronous and active-high.
- `GP_IN`  in  GPIO_WIDTH  host word, asynchronous to `CLK`.
- `SET`  in  4  static set ID of this instance.
- `GP_OUT`  out  GPIO_WIDTH  status word to the host.
- `PARAMS_DATA`  out  PARAM_COUNT*GPIO_WIDTH  parameter bank.
- `UPDATE`  out  1  one-cycle pulse on each committed write.
- `UPDATE_IDX`  out  4  slot index of the last commit.

## Operation
- **GP_IN fields** (W = GPIO_WIDTH):
  - TGL `[W-1]`: the host flips it to issue a word.
  - KIND `[W-2:W-3]`: 00 CMD, 01 DATA_LO, 10 DATA_HI, 11 ABORT.
  - WSET `[W-5:W-8]`: target set (CMD only).
  - IDX `[3:0]`: slot index (CMD only).
  - PAY `[W/2-1:0]`: payload half (DATA words).
- **GP_OUT fields:**
  - ACK `[W-1]`: last accepted TGL.
  - ERR `[W-2]`.
  - STATE `[W-3:W-4]`: 0 IDLE, 1 WAIT_LO, 2 WAIT_HI.
  - `[7:4]`: commit count mod 16.
  - `[3:0]`: latched index.
  - All other bits 0.
- **Input synchronisation:**
  - `GP_IN` passes through two flop stages; a third flop holds the previous synchronised TGL.
  - A word is detected when synchronised TGL differs from its previous value.
  - The word is decoded from the second stage.
- **Every detected word** updates ACK to the new TGL. Other effects by KIND and state:
  - **CMD, WSET==SET, IDX<PARAM_COUNT:** latch IDX; clear ERR; clear IGN; go to WAIT_LO.
  - **CMD, WSET==SET, IDX≥PARAM_COUNT:** set ERR; go to IDLE.
  - **CMD, WSET≠SET:** set IGN; go to IDLE; ERR unchanged. A CMD in any state discards any pending transaction.
  - **DATA_LO in WAIT_LO:** latch PAY as the low half; go to WAIT_HI.
  - **DATA_HI in WAIT_HI:** write {PAY, low half} into slot IDX; pulse UPDATE; UPDATE_IDX←IDX; commit count +1 (wraps 15→0); go to IDLE.
  - **DATA word in IDLE with IGN=1:** ignored; no state or ERR change.
  - **Any other DATA word** (IDLE with IGN=0, DATA_HI in WAIT_LO, DATA_LO in WAIT_HI): set ERR; go to IDLE; no commit.
  - **ABORT:** go to IDLE; clear ERR; clear IGN; no commit.
- ERR is sticky until a valid CMD or an ABORT.
- Slots not written keep their value.

## Timing
- **Reset values:**
  - `GP_OUT` = 0, `PARAMS_DATA` = 0, `UPDATE` = 0, `UPDATE_IDX` = 0.
  - State IDLE, IGN = 0, sync flops 0.
- The host holds TGL=0 across reset release.
- **Latency:** TGL sampled at edge k → word processed at edge k+2. `GP_OUT`, `PARAMS_DATA`, `UPDATE` and `UPDATE_IDX` all change at edge k+2. `UPDATE` is high for exactly one cycle.
- **Host rules:**
  - All non-TGL bits are stable from ≥1 cycle before the TGL flip until ACK equals TGL.
  - At most one outstanding word: the host waits for ACK==TGL before flipping again.
- **Reset mid-transaction:** asynchronous clear of the whole bank and FSM. Partial data is lost, and the host must restart with a CMD.
- There are no simultaneous-word cases by construction. A TGL flip while RST is high is lost.

## Test plan
- **Reset:** assert RST mid-WAIT_HI → all outputs 0, STATE=0 immediately. Release with TGL=0 → no spurious ACK.
- **Full write**, SET=3, 32-bit:
  - Stimulus: CMD(WSET=3, IDX=5), DATA_LO 0xBEEF, DATA_HI 0xDEAD, each flip awaiting ACK.
  - Required: slot 5 = 0xDEADBEEF; UPDATE one cycle with UPDATE_IDX=5; count=1.
  - Required: each ACK follows its TGL flip by 2 edges; other slots 0.
- **Sequence errors:**
  - DATA_HI directly after CMD → ERR=1, STATE=0, no UPDATE.
  - A following valid CMD → ERR=0.
- **Index error:** CMD IDX=15 with PARAM_COUNT=12 → ERR=1, ACK toggles, bank unchanged.
- **Set filtering:** CMD WSET=2 to an instance with SET=3, then DATA_LO and DATA_HI → ACKs toggle; ERR stays 0; no commit.
- **Abort and wrap:**
  - ABORT from WAIT_HI → IDLE, ERR=0, no commit.
  - 17 full writes → count field reads 1.
